// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - sizing helpers, signedness modes and radix-8 Booth digit decode
package booth_pkg;

  localparam logic [1:0] SM_UU = 2'b00;
  localparam logic [1:0] SM_US = 2'b01;
  localparam logic [1:0] SM_SU = 2'b10;
  localparam logic [1:0] SM_SS = 2'b11;

  typedef struct packed {
    logic inv;
    logic x4;
    logic x3;
    logic x2;
    logic x1;
    logic zero;
  } booth_sel_t;

  function automatic int num_pps(input int w);
    return (w + 3) / 3;
  endfunction

  function automatic int clog2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < x) r = i + 1;
    return r;
  endfunction

  // Number of live items after lvl pairwise-add levels starting from n.
  function automatic int tree_count(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  // Digit = -4*g[3] + 2*g[2] + g[1] + g[0]; 1111 decodes as plain zero.
  function automatic booth_sel_t booth_decode(input logic [3:0] grp);
    booth_sel_t s;
    s = '0;
    case (grp)
      4'b0001, 4'b0010: s.x1 = 1'b1;
      4'b0011, 4'b0100: s.x2 = 1'b1;
      4'b0101, 4'b0110: s.x3 = 1'b1;
      4'b0111:          s.x4 = 1'b1;
      4'b1000:          begin s.x4 = 1'b1; s.inv = 1'b1; end
      4'b1001, 4'b1010: begin s.x3 = 1'b1; s.inv = 1'b1; end
      4'b1011, 4'b1100: begin s.x2 = 1'b1; s.inv = 1'b1; end
      4'b1101, 4'b1110: begin s.x1 = 1'b1; s.inv = 1'b1; end
      default:          s.zero = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_r8_pp_gen.sv
// rtl/booth_r8_pp_gen.sv - one Booth group to a shifted, one's-complemented partial product
module booth_r8_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX   = 0
) (
  input  logic [3:0]         grp,
  input  logic [WIDTH+3:0]   a_x1,
  input  logic [WIDTH+3:0]   a_x3,
  output logic [2*WIDTH-1:0] pp,
  output logic               corr
);

  booth_sel_t       sel;
  logic [WIDTH+3:0] mag;
  logic [WIDTH+3:0] mag_inv;

  // Negation is ~mag here plus a +1 at bit 3*IDX carried out on corr.
  always_comb begin
    sel = booth_decode(grp);
    mag = '0;
    if (!sel.zero)
      mag = ({(WIDTH+4){sel.x1}} & a_x1)
          | ({(WIDTH+4){sel.x2}} & {a_x1[WIDTH+2:0], 1'b0})
          | ({(WIDTH+4){sel.x3}} & a_x3)
          | ({(WIDTH+4){sel.x4}} & {a_x1[WIDTH+1:0], 2'b00});
    mag_inv = mag ^ {(WIDTH+4){sel.inv}};
    pp      = (2*WIDTH)'(signed'(mag_inv)) << (3 * IDX);
    corr    = sel.inv;
  end

endmodule

// File: rtl/booth_r8_mult_pipe.sv
// rtl/booth_r8_mult_pipe.sv - pipelined radix-8 Booth multiplier with valid/ready handshake
// Define BOOTH_R8_SKID_EN for a 2-entry output skid buffer and a registered in_ready.
module booth_r8_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_sign_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NUM_PPS   = num_pps(WIDTH);
  localparam int ITEMS     = NUM_PPS + 1;
  localparam int TREE_LVLS = clog2(ITEMS);
  localparam int BX        = 3 * NUM_PPS - WIDTH;
  localparam int PW        = 2 * WIDTH;

  logic               en;
  logic [WIDTH+3:0]   a_ext;
  logic [3*NUM_PPS:0] b_ext;

  logic               s1_v;
  logic [WIDTH+3:0]   s1_a;
  logic [WIDTH+3:0]   s1_a3;
  logic [3*NUM_PPS:0] s1_b;
  logic [TAG_W-1:0]   s1_tag;

  logic [PW-1:0]      pp_c [NUM_PPS];
  logic [NUM_PPS-1:0] corr_c;

  // Level 0 is the S2 register; the second dimension is oversized so 2j+1 never leaves range.
  logic [PW-1:0]      tree     [TREE_LVLS+1][2*ITEMS];
  logic [PW-1:0]      tree_nxt [TREE_LVLS+1][2*ITEMS];
  logic [TREE_LVLS:0] t_v;
  logic [TAG_W-1:0]   t_tag [TREE_LVLS+1];

  logic               o_v;
  logic [PW-1:0]      o_p;
  logic [TAG_W-1:0]   o_tag;

  assign a_ext = {{4{in_sign_mode[1] & in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{BX{in_sign_mode[0] & in_b[WIDTH-1]}}, in_b, 1'b0};

  for (genvar i = 0; i < NUM_PPS; i++) begin : g_pp
    booth_r8_pp_gen #(.WIDTH(WIDTH), .IDX(i)) u_pp (
      .grp  (s1_b[3*i +: 4]),
      .a_x1 (s1_a),
      .a_x3 (s1_a3),
      .pp   (pp_c[i]),
      .corr (corr_c[i])
    );
  end

  always_comb begin
    for (int l = 0; l <= TREE_LVLS; l++)
      for (int j = 0; j < 2 * ITEMS; j++)
        tree_nxt[l][j] = '0;
    for (int i = 0; i < NUM_PPS; i++) begin
      tree_nxt[0][i]             = pp_c[i];
      tree_nxt[0][NUM_PPS][3*i]  = corr_c[i];
    end
    for (int l = 1; l <= TREE_LVLS; l++)
      for (int j = 0; j < ITEMS; j++)
        if (2*j + 1 < tree_count(ITEMS, l - 1))
          tree_nxt[l][j] = tree[l-1][2*j] + tree[l-1][2*j+1];
        else if (2*j < tree_count(ITEMS, l - 1))
          tree_nxt[l][j] = tree[l-1][2*j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      t_v   <= '0;
      o_v   <= 1'b0;
      o_p   <= '0;
      o_tag <= '0;
    end else if (en) begin
      s1_v  <= in_valid;
      t_v   <= {t_v[TREE_LVLS-1:0], s1_v};
      o_v   <= t_v[TREE_LVLS];
      o_p   <= tree[TREE_LVLS][0];
      o_tag <= t_tag[TREE_LVLS];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_a     <= a_ext;
      s1_a3    <= a_ext + {a_ext[WIDTH+2:0], 1'b0};
      s1_b     <= b_ext;
      s1_tag   <= in_tag;
      tree     <= tree_nxt;
      t_tag[0] <= s1_tag;
      for (int l = 1; l <= TREE_LVLS; l++)
        t_tag[l] <= t_tag[l-1];
    end
  end

`ifdef BOOTH_R8_SKID_EN
  logic [1:0]       sk_cnt;
  logic [PW-1:0]    sk_p   [2];
  logic [TAG_W-1:0] sk_tag [2];
  logic             sk_pop;
  logic             sk_direct;
  logic             sk_push;

  // OUT is either consumed straight through (buffer empty) or pushed; the pipe only stops when full.
  assign en        = ~sk_cnt[1];
  assign sk_pop    = out_ready & (sk_cnt != 2'd0);
  assign sk_direct = out_ready & (sk_cnt == 2'd0);
  assign sk_push   = en & o_v & ~sk_direct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sk_cnt <= 2'd0;
    else        sk_cnt <= sk_cnt - 2'(sk_pop) + 2'(sk_push);
  end

  always_ff @(posedge clk) begin
    if (sk_pop) begin
      sk_p[0]   <= sk_p[1];
      sk_tag[0] <= sk_tag[1];
    end
    if (sk_push) begin
      if (sk_cnt == 2'd0 || sk_pop) begin
        sk_p[0]   <= o_p;
        sk_tag[0] <= o_tag;
      end else begin
        sk_p[1]   <= o_p;
        sk_tag[1] <= o_tag;
      end
    end
  end

  assign out_valid   = (sk_cnt != 2'd0) | o_v;
  assign out_product = (sk_cnt != 2'd0) ? sk_p[0]   : o_p;
  assign out_tag     = (sk_cnt != 2'd0) ? sk_tag[0] : o_tag;
`else
  assign en          = ~(o_v & ~out_ready);
  assign out_valid   = o_v;
  assign out_product = o_p;
  assign out_tag     = o_tag;
`endif

  assign in_ready = en;

endmodule

// File: tb/tb_booth_r8_mult_pipe.sv
// tb/tb_booth_r8_mult_pipe.sv - directed and streaming checks of booth_r8_mult_pipe at WIDTH=8
module tb_booth_r8_mult_pipe;
  import booth_pkg::*;

  // 3 partial products + correction = 4 items -> 2 adder levels.
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_sign_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [3:0]  out_tag;

  booth_r8_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sign_mode (in_sign_mode),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  t;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  bit          lat_chk = 0;
  logic [15:0] cur_exp = '0;
  bit          prev_stall = 0;
  logic [15:0] prev_p = '0;
  logic [3:0]  prev_t = '0;

  localparam logic [7:0]  D_A [10] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h80, 8'h03, 8'h00};
  localparam logic [7:0]  D_B [10] = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h02, 8'h7F, 8'hFD, 8'hFF};
  localparam logic [1:0]  D_M [10] = '{SM_SS, SM_UU, SM_SU, SM_US, SM_SS, SM_SS, SM_UU, SM_SU, SM_US, SM_UU};
  localparam logic [15:0] D_P [10] = '{16'h4000, 16'hFE01, 16'hFF01, 16'h8080, 16'hC080,
                                       16'h0001, 16'h0100, 16'hC080, 16'hFFF7, 16'h0000};
  localparam logic [7:0]  EDGE_B [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    logic signed [31:0] sa, sbv, pr;
    sa  = m[1] ? 32'(signed'(a)) : 32'(a);
    sbv = m[0] ? 32'(signed'(b)) : 32'(b);
    pr  = sa * sbv;
    return pr[15:0];
  endfunction

  // Called just after a negedge with inputs already driven; returns whether the pair was taken.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (prev_stall) begin
      check("hold_product", 64'(out_product), 64'(prev_p));
      check("hold_tag", 64'(out_tag), 64'(prev_t));
    end
`ifndef BOOTH_R8_SKID_EN
    if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
`endif
    if (out_valid && out_ready) begin
      check("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("product", 64'(out_product), 64'(e.p));
        check("tag", 64'(out_tag), 64'(e.t));
        if (lat_chk) check("latency", 64'(cyc - e.c), 64'(LAT));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_p     = out_product;
    prev_t     = out_tag;
    if (acc) sb.push_back('{cur_exp, in_tag, cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [3:0] t, input logic [15:0] e, input bit rand_rdy);
    bit acc;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_sign_mode = m; in_tag = t; cur_exp = e;
    n = 0;
    do begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      tick(acc);
      n++;
    end while (!acc && n < 64);
    check("accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick(acc);
      n++;
    end
    repeat (LAT + 2) tick(acc);
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          k;
    logic [7:0]  ra, rb;
    logic [1:0]  rm;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sign_mode = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_product", 64'(out_product), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors one at a time, then the 1,0,0,1 bubble pattern, then back-to-back.
    lat_chk = 1;
    for (int i = 0; i < 10; i++) begin
      send(D_A[i], D_B[i], D_M[i], 4'(i + 1), D_P[i], 0);
      idle(LAT + 1);
    end
    send(D_A[0], D_B[0], D_M[0], 4'hA, D_P[0], 0);
    idle(2);
    send(D_A[3], D_B[3], D_M[3], 4'hB, D_P[3], 0);
    idle(LAT + 2);
    for (int i = 0; i < 10; i++) send(D_A[i], D_B[i], D_M[i], 4'(i), D_P[i], 0);
    drain();

    // 256 back-to-back random pairs; the latency check enforces one result per cycle in order.
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 2'($urandom);
      send(ra, rb, rm, 4'(i), ref_mul(ra, rb, rm), 0);
    end
    drain();

    // Backpressure: out_ready low for 10 cycles while the source keeps streaming.
    lat_chk = 0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c < 16);
      in_valid = 1'b1; in_a = 8'(k * 37 + 5); in_b = 8'(k * 91 + 3);
      in_sign_mode = 2'(k); in_tag = 4'(k);
      cur_exp = ref_mul(in_a, in_b, in_sign_mode);
      tick(acc);
`ifndef BOOTH_R8_SKID_EN
      if (c == 16) check("accept_on_release", 64'(acc), 64'd1);
`endif
      if (acc) k++;
    end
    drain();

    // Reset with operations in flight.
    lat_chk = 1;
    for (int i = 0; i < 4; i++) send(D_A[i], D_B[i], D_M[i], 4'(i), D_P[i], 0);
    idle(1);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_product", 64'(out_product), 64'd0);
    sb.delete();
    prev_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 4);
    send(D_A[4], D_B[4], D_M[4], 4'hC, D_P[4], 0);
    drain();

    // Sweep every A against edge and random B in all modes, with random out_ready.
    lat_chk = 0;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 256; a++)
        for (int j = 0; j < 6; j++) begin
          rb = (j < 5) ? EDGE_B[j] : 8'($urandom);
          send(8'(a), rb, 2'(m), 4'(a + j), ref_mul(8'(a), rb, 2'(m)), 1);
        end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
